// File: rtl/decoder_pkg.sv
// decoder_pkg: shared types, widths and one-hot helper for the pulse decoder
package decoder_pkg;
  typedef enum logic [1:0] {IDLE, HOLD, GAP} state_e;
  localparam int CODE_W = 2;
  localparam int ONEHOT_W = 4;
  function automatic logic [ONEHOT_W-1:0] onehot_of(input logic [CODE_W-1:0] c);
    return ONEHOT_W'(1) << c;
  endfunction
endpackage

// File: rtl/hold_counter.sv
// hold_counter: loadable down-counter with zero flag, shared by hold and gap periods
module hold_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             dec_i,
  input  logic [CNT_W-1:0] val_i,
  output logic             zero_o
);
  logic [CNT_W-1:0] count_q, count_d;
  always_comb count_d = load_i ? val_i : dec_i ? count_q - 1'b1 : count_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else count_q <= count_d;
  end
  assign zero_o = (count_q == '0);
endmodule

// File: rtl/onehot_pulse_decoder.sv
// onehot_pulse_decoder: accepts a 2-bit code and drives its one-hot strobe
// for HOLD_CYCLES cycles, followed by GAP_CYCLES forced-zero cycles
module onehot_pulse_decoder import decoder_pkg::*; #(
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 1,
  parameter int CNT_W       = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                in_valid,
  input  logic [CODE_W-1:0]   code,
  output logic                in_ready,
  output logic [ONEHOT_W-1:0] d_out,
  output logic                out_active,
  output logic [7:0]          decode_count
);
  state_e state_q, state_d;
  logic [ONEHOT_W-1:0] d_q, d_d;
  logic [7:0] cnt_q, cnt_d;
  logic load, dec, zero;
  logic [CNT_W-1:0] load_val;
  assign in_ready = (state_q == IDLE) & en & ~rst;
  hold_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk(clk), .rst(rst), .load_i(load), .dec_i(dec), .val_i(load_val), .zero_o(zero)
  );
  always_comb begin
    state_d  = state_q;
    d_d      = d_q;
    cnt_d    = cnt_q;
    load     = 1'b0;
    dec      = 1'b0;
    load_val = CNT_W'(HOLD_CYCLES - 1);
    unique case (state_q)
      IDLE: if (in_valid && in_ready) begin
        d_d     = onehot_of(code);
        cnt_d   = cnt_q + 8'd1;
        load    = 1'b1;
        state_d = HOLD;
      end
      HOLD: if (!en) begin
        d_d     = '0;
        state_d = IDLE;
      end else if (zero) begin
        d_d      = '0;
        load     = GAP_CYCLES > 0;
        load_val = CNT_W'(GAP_CYCLES - 1);
        state_d  = GAP_CYCLES > 0 ? GAP : IDLE;
      end else dec = 1'b1;
      GAP: if (!en || zero) state_d = IDLE;
           else dec = 1'b1;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      d_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
    end
  end
  assign d_out        = d_q;
  assign out_active   = |d_q;
  assign decode_count = cnt_q;
endmodule
